// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS fetch front end
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK  = ~32'h3;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - priority mux for the next pc (jump > branch > pending > pc_plus4)
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         pending,
  input  logic [N-1:0] pending_target,
  input  logic [N-1:0] pc_plus4,
  output logic [N-1:0] next_pc,
  output logic         redirect,
  output logic [N-1:0] redirect_target,
  output logic         redirect_misaligned
);

  localparam logic [N-1:0] ALIGN_MASK = N'(WORD_ALIGN_MASK);

  always_comb begin
    redirect            = jump | branch_taken;
    redirect_target     = '0;
    redirect_misaligned = 1'b0;
    if (jump) begin
      redirect_target     = jump_target & ALIGN_MASK;
      redirect_misaligned = |jump_target[1:0];
    end else if (branch_taken) begin
      redirect_target     = branch_target & ALIGN_MASK;
      redirect_misaligned = |branch_target[1:0];
    end

    // The pending target was masked when it was latched.
    if (redirect) begin
      next_pc = redirect_target;
    end else if (pending) begin
      next_pc = pending_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - pc register and fetch sequencer; optional PC_ALIGN_CHECK_EN adds misalign_err
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pc_plus4,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  input  logic         stall,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] pc,
  output logic         redirect_pending
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic         misalign_err
`endif
);

  pc_state_t    state;
  logic [N-1:0] pending_target;
  logic [N-1:0] next_pc;
  logic         redirect;
  logic [N-1:0] redirect_target;
  logic         redirect_misaligned;
  logic         handshake;

  assign handshake = imem_req_valid & imem_req_ready;

  next_pc_sel #(.N(N)) u_next_pc_sel (
    .jump                (jump),
    .jump_target         (jump_target),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .pending             (redirect_pending),
    .pending_target      (pending_target),
    .pc_plus4            (pc_plus4),
    .next_pc             (next_pc),
    .redirect            (redirect),
    .redirect_target     (redirect_target),
    .redirect_misaligned (redirect_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= BOOT;
      pc               <= RESET_PC;
      imem_req_valid   <= 1'b0;
      redirect_pending <= 1'b0;
      pending_target   <= '0;
    end else begin
      case (state)
        BOOT: begin
          state          <= FETCH;
          imem_req_valid <= 1'b1;
        end
        FETCH: begin
          if (handshake) begin
            pc <= next_pc;
            if (stall) begin
              state          <= HOLD;
              imem_req_valid <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            state          <= FETCH;
            imem_req_valid <= 1'b1;
          end
        end
        default: begin
          state          <= BOOT;
          imem_req_valid <= 1'b0;
        end
      endcase

      // A handshake always consumes whatever redirect was pending or arriving.
      if (handshake) begin
        redirect_pending <= 1'b0;
      end else if (redirect) begin
        redirect_pending <= 1'b1;
        pending_target   <= redirect_target;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (redirect && redirect_misaligned) begin
      misalign_err <= 1'b1;
    end
  end
`endif

endmodule
